game_logic: RTL and testbench

GAME_LOGIC -- requirements
Module: game_logic

---
 rtl/game_logic_if.sv | 26 ++
 rtl/game_logic.sv | 239 +++++++++++++++++++++++
 tb/tb_game_logic.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/game_logic_if.sv
// Player/frame inputs and rendered game state shared between the game core and its environment.
interface game_logic_if;
  logic       frame_tick;
  logic       p1_up;
  logic       p1_dn;
  logic       p2_up;
  logic       p2_dn;
  logic       start;
  logic [9:0] p1_y;
  logic [9:0] p2_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] state;

  modport master (
    output frame_tick, p1_up, p1_dn, p2_up, p2_dn, start,
    input  p1_y, p2_y, ball_x, ball_y, score1, score2, state
  );

  modport slave (
    input  frame_tick, p1_up, p1_dn, p2_up, p2_dn, start,
    output p1_y, p2_y, ball_x, ball_y, score1, score2, state
  );
endinterface

// File: rtl/game_logic.sv
// Two-player paddle game core: serve/play/score state machine updated once per frame_tick.
module game_logic #(
  parameter int SCR_W    = 800,
  parameter int SCR_H    = 480,
  parameter int PAD_H    = 64,
  parameter int PAD_W    = 8,
  parameter int BALL     = 8,
  parameter int STEP     = 4,
  parameter int SPD      = 2,
  parameter int WIN      = 9,
  parameter int P1_X     = 16,
  parameter int P2_X     = 776,
  parameter int SERVE_FR = 60
) (
  input  logic         P_CLK,
  input  logic         NRST,
  game_logic_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int FC_W = (SERVE_FR > 1) ? $clog2(SERVE_FR) : 1;

  localparam logic [9:0] PAD_MAX_V = 10'(SCR_H - PAD_H);
  localparam logic [9:0] PAD_MID_V = 10'((SCR_H - PAD_H) / 2);
  localparam logic [9:0] BALL_CX_V = 10'((SCR_W - BALL) / 2);
  localparam logic [9:0] BALL_CY_V = 10'((SCR_H - BALL) / 2);
  localparam logic [9:0] STEP_V    = 10'(STEP);
  localparam logic [9:0] P1_REST_V = 10'(P1_X + PAD_W);
  localparam logic [9:0] P2_REST_V = 10'(P2_X - BALL);
  localparam logic [9:0] Y_MAX_V   = 10'(SCR_H - BALL);
  localparam logic [3:0] WIN_V     = 4'(WIN);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(SERVE_FR - 1);

  localparam logic signed [10:0] SPD_S     = 11'(SPD);
  localparam logic signed [10:0] BALL_S    = 11'(BALL);
  localparam logic signed [10:0] PAD_H_S   = 11'(PAD_H);
  localparam logic signed [10:0] P1_X_S    = 11'(P1_X);
  localparam logic signed [10:0] P1_EDGE_S = 11'(P1_X + PAD_W);
  localparam logic signed [10:0] P2_X_S    = 11'(P2_X);
  localparam logic signed [10:0] P2_EDGE_S = 11'(P2_X + PAD_W);
  localparam logic signed [10:0] X_MAX_S   = 11'(SCR_W - BALL);
  localparam logic signed [10:0] Y_MAX_S   = 11'(SCR_H - BALL);
  localparam logic signed [10:0] ZERO_S    = 11'sd0;

  state_t           state_q, state_d;
  logic [9:0]       p1_y_q, p1_y_d;
  logic [9:0]       p2_y_q, p2_y_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic signed [10:0] dx_q, dx_d;
  logic signed [10:0] dy_q, dy_d;
  logic [3:0]       score1_q, score1_d;
  logic [3:0]       score2_q, score2_d;
  logic             serve_p2_q, serve_p2_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             start_q, start_d;

  logic             start_edge;
  logic signed [10:0] nx, ny, p1_s, p2_s;
  logic             p1_hit, p2_hit;
  logic [9:0]       p1_move, p2_move;
  logic [3:0]       score1_inc, score2_inc;

  function automatic logic [9:0] move_pad(input logic [9:0] y, input logic up, input logic dn);
    logic [9:0] r;
    r = y;
    if (up && !dn) begin
      r = (y < STEP_V) ? 10'd0 : y - STEP_V;
    end else if (dn && !up) begin
      r = (y > PAD_MAX_V - STEP_V) ? PAD_MAX_V : y + STEP_V;
    end
    return r;
  endfunction

  assign start_edge = bus.start & ~start_q;

  // Candidate ball position and collision tests use the paddles as they stood before this tick.
  assign nx   = $signed({1'b0, ball_x_q}) + dx_q;
  assign ny   = $signed({1'b0, ball_y_q}) + dy_q;
  assign p1_s = $signed({1'b0, p1_y_q});
  assign p2_s = $signed({1'b0, p2_y_q});

  assign p1_hit = dx_q[10] && (nx <= P1_EDGE_S) && (nx + BALL_S > P1_X_S) &&
                  (ny + BALL_S > p1_s) && (ny < p1_s + PAD_H_S);
  assign p2_hit = !dx_q[10] && (dx_q != ZERO_S) && (nx + BALL_S >= P2_X_S) && (nx < P2_EDGE_S) &&
                  (ny + BALL_S > p2_s) && (ny < p2_s + PAD_H_S);

  assign p1_move = move_pad(p1_y_q, bus.p1_up, bus.p1_dn);
  assign p2_move = move_pad(p2_y_q, bus.p2_up, bus.p2_dn);

  assign score1_inc = (score1_q >= WIN_V) ? WIN_V : score1_q + 4'd1;
  assign score2_inc = (score2_q >= WIN_V) ? WIN_V : score2_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    p1_y_d      = p1_y_q;
    p2_y_d      = p2_y_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    serve_p2_d  = serve_p2_q;
    frame_cnt_d = frame_cnt_q;
    start_d     = bus.start;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d     = SERVE;
          serve_p2_d  = 1'b1;
          frame_cnt_d = '0;
        end
      end

      SERVE: begin
        if (bus.frame_tick) begin
          p1_y_d = p1_move;
          p2_y_d = p2_move;
          if (frame_cnt_q == FC_LAST) begin
            state_d     = PLAY;
            frame_cnt_d = '0;
            dx_d        = serve_p2_q ? SPD_S : -SPD_S;
            dy_d        = SPD_S;
          end else begin
            frame_cnt_d = frame_cnt_q + FC_W'(1);
          end
        end
      end

      PLAY: begin
        if (bus.frame_tick) begin
          p1_y_d = p1_move;
          p2_y_d = p2_move;

          if (ny <= ZERO_S) begin
            ball_y_d = 10'd0;
            dy_d     = SPD_S;
          end else if (ny >= Y_MAX_S) begin
            ball_y_d = Y_MAX_V;
            dy_d     = -SPD_S;
          end else begin
            ball_y_d = ny[9:0];
          end

          // A paddle return is resolved before the ball is allowed to leave the field.
          if (p1_hit) begin
            ball_x_d = P1_REST_V;
            dx_d     = SPD_S;
          end else if (p2_hit) begin
            ball_x_d = P2_REST_V;
            dx_d     = -SPD_S;
          end else if (nx < ZERO_S) begin
            score2_d    = score2_inc;
            ball_x_d    = BALL_CX_V;
            ball_y_d    = BALL_CY_V;
            serve_p2_d  = 1'b0;
            frame_cnt_d = '0;
            state_d     = (score2_inc == WIN_V) ? OVER : SERVE;
          end else if (nx > X_MAX_S) begin
            score1_d    = score1_inc;
            ball_x_d    = BALL_CX_V;
            ball_y_d    = BALL_CY_V;
            serve_p2_d  = 1'b1;
            frame_cnt_d = '0;
            state_d     = (score1_inc == WIN_V) ? OVER : SERVE;
          end else begin
            ball_x_d = nx[9:0];
          end
        end
      end

      OVER: begin
        if (start_edge) begin
          state_d     = IDLE;
          p1_y_d      = PAD_MID_V;
          p2_y_d      = PAD_MID_V;
          ball_x_d    = BALL_CX_V;
          ball_y_d    = BALL_CY_V;
          dx_d        = SPD_S;
          dy_d        = SPD_S;
          score1_d    = '0;
          score2_d    = '0;
          serve_p2_d  = 1'b1;
          frame_cnt_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // start_q resets high so a start button held through reset release is not seen as a press.
  always_ff @(posedge P_CLK or negedge NRST) begin
    if (!NRST) begin
      state_q     <= IDLE;
      p1_y_q      <= PAD_MID_V;
      p2_y_q      <= PAD_MID_V;
      ball_x_q    <= BALL_CX_V;
      ball_y_q    <= BALL_CY_V;
      dx_q        <= SPD_S;
      dy_q        <= SPD_S;
      score1_q    <= '0;
      score2_q    <= '0;
      serve_p2_q  <= 1'b1;
      frame_cnt_q <= '0;
      start_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      p1_y_q      <= p1_y_d;
      p2_y_q      <= p2_y_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      serve_p2_q  <= serve_p2_d;
      frame_cnt_q <= frame_cnt_d;
      start_q     <= start_d;
    end
  end

  assign bus.p1_y   = p1_y_q;
  assign bus.p2_y   = p2_y_q;
  assign bus.ball_x = ball_x_q;
  assign bus.ball_y = ball_y_q;
  assign bus.score1 = score1_q;
  assign bus.score2 = score2_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_game_logic.sv
// Directed bench for game_logic: serve timing, paddle clamps, walls, paddle return, scoring, game over and reset.
module tb_game_logic;

  logic p_clk;
  logic nrst;
  int   compared;
  int   mismatched;

  game_logic_if bus ();

  game_logic dut (
    .P_CLK (p_clk),
    .NRST  (nrst),
    .bus   (bus)
  );

  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  // Each comparison is one immediate assertion; failures are counted and reported.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Issues n frame ticks; outputs are stable for sampling when the task returns.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge p_clk) bus.frame_tick = 1'b1;
      @(negedge p_clk) bus.frame_tick = 1'b0;
    end
  endtask

  task automatic pulseStart();
    @(negedge p_clk) bus.start = 1'b1;
    @(negedge p_clk) bus.start = 1'b0;
  endtask

  // Linear directed sequence; expected values worked out by hand from the game rules.
  initial begin
    compared       = 0;
    mismatched     = 0;
    nrst           = 1'b0;
    bus.frame_tick = 1'b0;
    bus.p1_up      = 1'b0;
    bus.p1_dn      = 1'b0;
    bus.p2_up      = 1'b0;
    bus.p2_dn      = 1'b0;
    bus.start      = 1'b0;

    repeat (2) @(negedge p_clk);
    checkOutput("reset_state", 32'(bus.state), 32'd0);
    checkOutput("reset_p1_y", 32'(bus.p1_y), 32'd208);
    checkOutput("reset_p2_y", 32'(bus.p2_y), 32'd208);
    checkOutput("reset_ball_x", 32'(bus.ball_x), 32'd396);
    checkOutput("reset_ball_y", 32'(bus.ball_y), 32'd236);
    checkOutput("reset_score1", 32'(bus.score1), 32'd0);
    checkOutput("reset_score2", 32'(bus.score2), 32'd0);
    nrst = 1'b1;

    bus.p1_up = 1'b1;
    applyStimulus(1);
    checkOutput("idle_paddle_frozen", 32'(bus.p1_y), 32'd208);
    checkOutput("idle_stays_idle", 32'(bus.state), 32'd0);
    bus.p1_up = 1'b0;

    pulseStart();
    checkOutput("start_to_serve", 32'(bus.state), 32'd1);

    // Serve 1: p1 held up, drops 4 per tick and clamps at 0.
    bus.p1_up = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      applyStimulus(1);
      checkOutput("serve1_state", 32'(bus.state), (i < 60) ? 32'd1 : 32'd2);
      checkOutput("serve1_p1_up", 32'(bus.p1_y), (208 - 4 * i > 0) ? 32'(208 - 4 * i) : 32'd0);
      if (i == 30) checkOutput("serve1_ball_held", 32'(bus.ball_x), 32'd396);
    end
    bus.p1_up = 1'b0;

    // Rally 1: bottom wall at play tick 118, p2 misses at tick 199.
    for (int k = 1; k <= 199; k++) begin
      applyStimulus(1);
      if (k == 1)   checkOutput("play1_first_x", 32'(bus.ball_x), 32'd398);
      if (k == 117) checkOutput("play1_y_before_wall", 32'(bus.ball_y), 32'd470);
      if (k == 118) checkOutput("play1_y_at_wall", 32'(bus.ball_y), 32'd472);
      if (k == 119) checkOutput("play1_y_after_wall", 32'(bus.ball_y), 32'd470);
      if (k == 198) begin
        checkOutput("play1_x_edge", 32'(bus.ball_x), 32'd792);
        checkOutput("play1_edge_state", 32'(bus.state), 32'd2);
      end
    end
    checkOutput("miss1_score1", 32'(bus.score1), 32'd1);
    checkOutput("miss1_score2", 32'(bus.score2), 32'd0);
    checkOutput("miss1_ball_x", 32'(bus.ball_x), 32'd396);
    checkOutput("miss1_ball_y", 32'(bus.ball_y), 32'd236);
    checkOutput("miss1_state", 32'(bus.state), 32'd1);

    // Serve 2: p1 down 10 ticks then both 5 ticks; p2 down 18 ticks to 280.
    for (int i = 1; i <= 60; i++) begin
      bus.p1_dn = (i <= 15);
      bus.p1_up = (i > 10 && i <= 15);
      bus.p2_dn = (i <= 18);
      applyStimulus(1);
      if (i == 10) checkOutput("serve2_p1_down", 32'(bus.p1_y), 32'd40);
      if (i == 15) checkOutput("serve2_p1_both", 32'(bus.p1_y), 32'd40);
      if (i == 18) checkOutput("serve2_p2_down", 32'(bus.p2_y), 32'd280);
    end
    bus.p1_dn = 1'b0;
    bus.p1_up = 1'b0;
    bus.p2_dn = 1'b0;
    checkOutput("serve2_to_play", 32'(bus.state), 32'd2);

    // Rally 2: p2 returns at tick 186, top wall at tick 354, p1 misses at tick 571.
    for (int k = 1; k <= 571; k++) begin
      applyStimulus(1);
      if (k == 185) checkOutput("play2_x_pre_hit", 32'(bus.ball_x), 32'd766);
      if (k == 186) checkOutput("play2_p2_hit_x", 32'(bus.ball_x), 32'd768);
      if (k == 187) checkOutput("play2_x_after_hit", 32'(bus.ball_x), 32'd766);
      if (k == 353) checkOutput("play2_y_before_top", 32'(bus.ball_y), 32'd2);
      if (k == 354) checkOutput("play2_y_at_top", 32'(bus.ball_y), 32'd0);
      if (k == 355) checkOutput("play2_y_after_top", 32'(bus.ball_y), 32'd2);
      if (k == 570) checkOutput("play2_x_left_edge", 32'(bus.ball_x), 32'd0);
    end
    checkOutput("miss2_score1", 32'(bus.score1), 32'd1);
    checkOutput("miss2_score2", 32'(bus.score2), 32'd1);
    checkOutput("miss2_state", 32'(bus.state), 32'd1);
    checkOutput("miss2_ball_x", 32'(bus.ball_x), 32'd396);

    // Serve 3 toward p1, with a start press that must be ignored.
    applyStimulus(20);
    pulseStart();
    checkOutput("serve_ignores_start", 32'(bus.state), 32'd1);
    applyStimulus(40);
    checkOutput("serve3_to_play", 32'(bus.state), 32'd2);
    applyStimulus(1);
    checkOutput("play3_serve_left_x", 32'(bus.ball_x), 32'd394);

    // Asynchronous reset mid-play with start held high.
    @(negedge p_clk);
    bus.start = 1'b1;
    #2 nrst = 1'b0;
    #1;
    checkOutput("midreset_state", 32'(bus.state), 32'd0);
    checkOutput("midreset_score1", 32'(bus.score1), 32'd0);
    checkOutput("midreset_score2", 32'(bus.score2), 32'd0);
    checkOutput("midreset_ball_x", 32'(bus.ball_x), 32'd396);
    checkOutput("midreset_ball_y", 32'(bus.ball_y), 32'd236);
    checkOutput("midreset_p1_y", 32'(bus.p1_y), 32'd208);
    @(negedge p_clk) nrst = 1'b1;
    applyStimulus(5);
    checkOutput("held_start_no_serve", 32'(bus.state), 32'd0);
    @(negedge p_clk) bus.start = 1'b0;

    // Game 3: p2 never moves, p1 wins 9-0.
    pulseStart();
    for (int pt = 1; pt <= 9; pt++) begin
      applyStimulus(60 + 199);
      checkOutput("game3_score1", 32'(bus.score1), 32'(pt));
      checkOutput("game3_state", 32'(bus.state), (pt == 9) ? 32'd3 : 32'd1);
    end
    checkOutput("over_score2", 32'(bus.score2), 32'd0);

    bus.p1_up = 1'b1;
    applyStimulus(3);
    bus.p1_up = 1'b0;
    checkOutput("over_state_frozen", 32'(bus.state), 32'd3);
    checkOutput("over_score_frozen", 32'(bus.score1), 32'd9);
    checkOutput("over_p1_frozen", 32'(bus.p1_y), 32'd208);
    checkOutput("over_ball_frozen", 32'(bus.ball_x), 32'd396);

    pulseStart();
    checkOutput("over_to_idle", 32'(bus.state), 32'd0);
    checkOutput("idle_score1_cleared", 32'(bus.score1), 32'd0);
    checkOutput("idle_score2_cleared", 32'(bus.score2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
